// File: rtl/vc_shiftregisters_2d_ctrl_if.sv
// Stream and array-drive bundle for vc_shiftregisters_2d_ctrl.
// master = the controller, slave = column source / window consumer / array.
interface vc_shiftregisters_2d_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int HEIGHT     = 8,
    parameter int COL_BITS   = 16
);
    logic                         in_val;
    logic                         in_rdy;
    logic [DATA_WIDTH*HEIGHT-1:0] in_data;
    logic                         in_last;
    logic [HEIGHT-1:0]            sr_en;
    logic [HEIGHT-1:0]            sr_val_in;
    logic [DATA_WIDTH*HEIGHT-1:0] sr_data_in;
    logic                         win_val;
    logic                         win_rdy;
    logic [COL_BITS-1:0]          win_col;
    logic                         win_last;

    modport master (
        input  in_val, in_data, in_last, win_rdy,
        output in_rdy, sr_en, sr_val_in, sr_data_in, win_val, win_col, win_last
    );

    modport slave (
        output in_val, in_data, in_last, win_rdy,
        input  in_rdy, sr_en, sr_val_in, sr_data_in, win_val, win_col, win_last
    );
endinterface

// File: rtl/vc_shiftregisters_2d_ctrl.sv
// Fill/window/flush sequencer for a HEIGHT x WIDTH shift-register window array.
// Optional VC_SR2D_CTRL_STATS_EN adds a 32-bit count of consumed windows (win_count).
module vc_shiftregisters_2d_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int HEIGHT     = 8,
    parameter int WIDTH      = 8,
    parameter int COL_BITS   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    vc_shiftregisters_2d_ctrl_if.master bus
`ifdef VC_SR2D_CTRL_STATS_EN
    ,
    output logic [31:0]                 win_count
`endif
);
    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int FLUSH_W = $clog2(WIDTH);
    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_FULL  = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FILL_W-1:0]    r_fill;
    logic [FILL_W-1:0]    w_fill_nxt;
    logic [FILL_W-1:0]    w_fill_inc;
    logic [COL_BITS-1:0]  r_col;
    logic [COL_BITS-1:0]  w_col_nxt;
    logic [FLUSH_W-1:0]   r_flush_cnt;
    logic [FLUSH_W-1:0]   w_flush_cnt_nxt;
    logic                 r_win_val;
    logic                 w_win_val_nxt;
    logic [COL_BITS-1:0]  r_win_col;
    logic [COL_BITS-1:0]  w_win_col_nxt;
    logic                 r_win_last;
    logic                 w_win_last_nxt;
    logic                 w_in_rdy;
    logic                 w_shift;
    logic                 w_flushing;

    // Input acceptance: a pending unconsumed window stalls the array (win_rdy -> in_rdy is combinational)
    always_comb begin
        w_in_rdy = 1'b0;
        if (reset) begin
            w_in_rdy = 1'b0;
        end else if ((r_state == S_FILL || r_state == S_FULL) && !(r_win_val && !bus.win_rdy)) begin
            w_in_rdy = 1'b1;
        end else begin
            w_in_rdy = 1'b0;
        end
    end

    assign w_shift    = bus.in_val & w_in_rdy;
    assign w_flushing = ~reset & (r_state == S_FLUSH);
    assign w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);

    assign bus.in_rdy     = w_in_rdy;
    assign bus.sr_en      = {HEIGHT{w_shift | w_flushing}};
    assign bus.sr_val_in  = {HEIGHT{w_shift}};
    assign bus.sr_data_in = w_shift ? bus.in_data : {(DATA_WIDTH*HEIGHT){1'b0}};
    assign bus.win_val    = r_win_val;
    assign bus.win_col    = r_win_col;
    assign bus.win_last   = r_win_last;

    // Next-state, counter and window-register update logic
    always_comb begin
        w_state_nxt     = r_state;
        w_fill_nxt      = r_fill;
        w_col_nxt       = r_col;
        w_flush_cnt_nxt = r_flush_cnt;
        w_win_val_nxt   = r_win_val;
        w_win_col_nxt   = r_win_col;
        w_win_last_nxt  = r_win_last;

        if (w_shift) begin
            w_fill_nxt = w_fill_inc;
            w_col_nxt  = r_col + COL_BITS'(1);
        end else begin
            w_fill_nxt = r_fill;
            w_col_nxt  = r_col;
        end

        case (r_state)
            S_FILL, S_FULL: begin
                if (w_shift && bus.in_last) begin
                    // A line shorter than the window never produces one
                    w_state_nxt = (w_fill_inc == FILL_FULL) ? S_DRAIN : S_FLUSH;
                end else if (w_shift && (w_fill_inc == FILL_FULL)) begin
                    w_state_nxt = S_FULL;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_DRAIN: begin
                w_state_nxt = bus.win_rdy ? S_FLUSH : S_DRAIN;
            end
            S_FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_state_nxt     = S_FILL;
                    w_fill_nxt      = {FILL_W{1'b0}};
                    w_col_nxt       = {COL_BITS{1'b0}};
                    w_flush_cnt_nxt = {FLUSH_W{1'b0}};
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt + FLUSH_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase

        if (w_shift && (w_fill_inc == FILL_FULL)) begin
            w_win_val_nxt  = 1'b1;
            w_win_col_nxt  = r_col;
            w_win_last_nxt = bus.in_last;
        end else if (r_win_val && bus.win_rdy) begin
            w_win_val_nxt  = 1'b0;
        end else begin
            w_win_val_nxt  = r_win_val;
        end
    end

    // State, counters and window registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FILL;
            r_fill      <= {FILL_W{1'b0}};
            r_col       <= {COL_BITS{1'b0}};
            r_flush_cnt <= {FLUSH_W{1'b0}};
            r_win_val   <= 1'b0;
            r_win_col   <= {COL_BITS{1'b0}};
            r_win_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill      <= w_fill_nxt;
            r_col       <= w_col_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_win_val   <= w_win_val_nxt;
            r_win_col   <= w_win_col_nxt;
            r_win_last  <= w_win_last_nxt;
        end
    end

`ifdef VC_SR2D_CTRL_STATS_EN
    logic [31:0] r_win_count;

    // Consumed-window counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_count <= 32'd0;
        end else if (r_win_val && bus.win_rdy) begin
            r_win_count <= r_win_count + 32'd1;
        end else begin
            r_win_count <= r_win_count;
        end
    end

    assign win_count = r_win_count;
`endif
endmodule
